// File: rtl/ha_array_pkg.sv
// Shared constants and types for the approximate 8x8 half-adder array
// row accumulator.
package ha_array_pkg;

    localparam int HA_T_W    = 9;
    localparam int HA_B_W    = 7;
    localparam int HA_ROWS   = 4;
    localparam int HA_PROD_W = 16;
    localparam int HA_ACC_W  = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } ha_state_e;

    // One half-adder row pair: top (sum) row and bottom (carry) row.
    typedef struct packed {
        logic [HA_T_W-1:0] t;
        logic [HA_B_W-1:0] b;
    } ha_row_pair_t;

endpackage

// File: rtl/ha_row_weight.sv
// Combinational weighting of one row pair: R_k = (t + (b << 2)) << 2K,
// zero-extended to the accumulator width.
module ha_row_weight
    import ha_array_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [HA_T_W-1:0]   t_i,
    input  logic [HA_B_W-1:0]   b_i,
    output logic [HA_ACC_W-1:0] r_o
);

    // Carry row sits two bit positions above the top row; 10 bits holds
    // the largest pair value (1019) before the row shift.
    logic [9:0] base;

    assign base = {1'b0, t_i} + {1'b0, b_i, 2'b00};
    assign r_o  = {7'b0, base} << (2 * K);

endmodule

// File: rtl/ha_array_accumulator.sv
// Latches one set of four half-adder row pairs, sums them into a 17-bit
// accumulator over 4/ROWS_PER_CYCLE cycles, then holds the product until
// downstream takes it.
module ha_array_accumulator
    import ha_array_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [HA_T_W-1:0]    ha_array_0_t,
    input  logic [HA_B_W-1:0]    ha_array_0_b,
    input  logic [HA_T_W-1:0]    ha_array_1_t,
    input  logic [HA_B_W-1:0]    ha_array_1_b,
    input  logic [HA_T_W-1:0]    ha_array_2_t,
    input  logic [HA_B_W-1:0]    ha_array_2_b,
    input  logic [HA_T_W-1:0]    ha_array_3_t,
    input  logic [HA_B_W-1:0]    ha_array_3_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HA_PROD_W-1:0] p,
    output logic                 ovf
);

    localparam int         RPC      = ROWS_PER_CYCLE;
    localparam int         GROUPS   = HA_ROWS / RPC;
    localparam logic [1:0] LAST_CNT = 2'(GROUPS - 1);

    generate
        if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
            $error("ha_array_accumulator: ROWS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    ha_state_e            state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [HA_ACC_W-1:0]  acc_q, acc_d;
    ha_row_pair_t         rows_q [HA_ROWS];
    ha_row_pair_t         rows_d [HA_ROWS];
    ha_row_pair_t         in_rows [HA_ROWS];
    logic [HA_ACC_W-1:0]  weight [HA_ROWS];
    logic [HA_ACC_W-1:0]  group_sum;
    logic [1:0]           idx;

    assign in_rows[0] = {ha_array_0_t, ha_array_0_b};
    assign in_rows[1] = {ha_array_1_t, ha_array_1_b};
    assign in_rows[2] = {ha_array_2_t, ha_array_2_b};
    assign in_rows[3] = {ha_array_3_t, ha_array_3_b};

    generate
        for (genvar gi = 0; gi < HA_ROWS; gi++) begin : g_weight
            ha_row_weight #(.K(gi)) u_weight (
                .t_i (rows_q[gi].t),
                .b_i (rows_q[gi].b),
                .r_o (weight[gi])
            );
        end
    endgenerate

    // Sum of the RPC weighted rows belonging to the current group.
    always_comb begin
        group_sum = '0;
        idx       = '0;
        for (int j = 0; j < RPC; j++) begin
            idx       = 2'(int'(cnt_q) * RPC + j);
            group_sum = group_sum + weight[idx];
        end
    end

    // Next-state logic: accept in IDLE, accumulate in ACC, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rows_d  = rows_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rows_d  = in_rows;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + group_sum;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, accumulator and row registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < HA_ROWS; k++) begin
                rows_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            for (int k = 0; k < HA_ROWS; k++) begin
                rows_q[k] <= rows_d[k];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = acc_q[HA_PROD_W-1:0];
    assign ovf       = acc_q[HA_ACC_W-1];

endmodule
